bp_port_arbiter: RTL and testbench

Arbiter and update scheduler for the single-ported branch pattern history table (PHT) feeding the tournament chooser. Shares the one PHT port between fetch-stage lookups and execute-stage resolved-branch updates. Buffers updates in a small FIFO so fetch is normally never blocked. Generates the registered 2-bit correctness/update strobe consumed by the chooser state machine.

---
 rtl/bp_port_arbiter.sv | 157 +++++++++++++++
 tb/tb_bp_port_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_port_arbiter.sv
// Single-port PHT arbiter: fetch lookups vs. buffered execute-stage updates, with starvation flush.
// Optional same-cycle update bypass when the FIFO is empty is enabled by defining BP_UPDATE_BYPASS_EN.
module bp_port_arbiter #(
    parameter int IDX_W      = 7,
    parameter int QDEPTH     = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       if_req,
    input  logic [IDX_W-1:0]           if_idx,
    output logic                       if_gnt,
    output logic                       if_stall,
    input  logic                       ex_valid,
    input  logic                       ex_stall,
    input  logic [IDX_W-1:0]           ex_idx,
    input  logic                       ex_taken,
    input  logic                       ex_local_pred,
    input  logic                       ex_global_pred,
    output logic                       pht_en,
    output logic                       pht_we,
    output logic [IDX_W-1:0]           pht_addr,
    output logic                       pht_taken,
    output logic                       chooser_upd,
    output logic [1:0]                 correctness,
    output logic [$clog2(QDEPTH):0]    q_count
);

    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int STV_W = $clog2(STARVE_MAX + 1);

    typedef enum logic [0:0] {
        NORMAL = 1'b0,
        FLUSH  = 1'b1
    } state_t;

    state_t             state_reg, state_next;
    logic [IDX_W-1:0]   q_idx_reg   [QDEPTH];
    logic               q_taken_reg [QDEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]   count_reg, count_next;
    logic [STV_W-1:0]   starve_reg, starve_next;
    logic               chooser_upd_reg;
    logic [1:0]         correctness_reg;

    logic push_req;
    logic bypass;
    logic enq;
    logic q_nonempty;
    logic q_full;
    logic upd_g;

    assign push_req = ex_valid & ~ex_stall;

`ifdef BP_UPDATE_BYPASS_EN
    // An idle port with an empty queue lets the resolved branch write straight through.
    assign bypass = push_req & (count_reg == '0) & ~if_req;
`else
    assign bypass = 1'b0;
`endif

    assign enq        = push_req & ~bypass;
    assign q_nonempty = (count_reg != '0);
    assign q_full     = (count_reg == CNT_W'(QDEPTH));
    // A full queue always drains, so a simultaneous push can never be lost.
    assign upd_g      = q_nonempty & ((state_reg == FLUSH) | q_full | ~if_req);

    assign if_gnt   = if_req & ~upd_g;
    assign if_stall = if_req & upd_g;

    always_comb begin
        pht_en    = 1'b0;
        pht_we    = 1'b0;
        pht_addr  = if_idx;
        pht_taken = 1'b0;
        if (upd_g) begin
            pht_en    = 1'b1;
            pht_we    = 1'b1;
            pht_addr  = q_idx_reg[rd_ptr_reg];
            pht_taken = q_taken_reg[rd_ptr_reg];
        end else if (bypass) begin
            pht_en    = 1'b1;
            pht_we    = 1'b1;
            pht_addr  = ex_idx;
            pht_taken = ex_taken;
        end else if (if_gnt) begin
            pht_en    = 1'b1;
        end
    end

    // Queue storage: one register slot per entry, written when the write pointer selects it.
    generate
        for (genvar gi = 0; gi < QDEPTH; gi++) begin : g_slot
            always_ff @(posedge clk) begin
                if (enq && (wr_ptr_reg == PTR_W'(gi))) begin
                    q_idx_reg[gi]   <= ex_idx;
                    q_taken_reg[gi] <= ex_taken;
                end
            end
        end
    endgenerate

    always_comb begin
        count_next = count_reg;
        case ({enq, upd_g})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    always_comb begin
        starve_next = starve_reg;
        if (upd_g || !q_nonempty) begin
            starve_next = '0;
        end else if (starve_reg != STV_W'(STARVE_MAX)) begin
            starve_next = starve_reg + STV_W'(1);
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            NORMAL: if (starve_next == STV_W'(STARVE_MAX)) state_next = FLUSH;
            FLUSH:  if (count_next == '0)                  state_next = NORMAL;
            default: state_next = NORMAL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg       <= NORMAL;
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            count_reg       <= '0;
            starve_reg      <= '0;
            chooser_upd_reg <= 1'b0;
            correctness_reg <= 2'b00;
        end else begin
            state_reg       <= state_next;
            count_reg       <= count_next;
            starve_reg      <= starve_next;
            chooser_upd_reg <= push_req;
            if (enq)   wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (upd_g) rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            if (push_req) begin
                correctness_reg <= {ex_local_pred == ex_taken, ex_global_pred == ex_taken};
            end
        end
    end

    assign chooser_upd = chooser_upd_reg;
    assign correctness = correctness_reg;
    assign q_count     = count_reg;

endmodule

// File: tb/tb_bp_port_arbiter.sv
// Scoreboard bench for bp_port_arbiter: stimulus queues expected PHT writes and chooser strobes,
// a negedge monitor pops and compares them; directed checks cover grants, stalls and occupancy.
module tb_bp_port_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       if_req = 1'b0;
    logic [6:0] if_idx = '0;
    logic       if_gnt, if_stall;
    logic       ex_valid = 1'b0;
    logic       ex_stall = 1'b0;
    logic [6:0] ex_idx = '0;
    logic       ex_taken = 1'b0;
    logic       ex_local_pred = 1'b0;
    logic       ex_global_pred = 1'b0;
    logic       pht_en, pht_we, pht_taken;
    logic [6:0] pht_addr;
    logic       chooser_upd;
    logic [1:0] correctness;
    logic [2:0] q_count;

    int total  = 0;
    int passed = 0;

    logic [7:0] upd_q[$];
    logic [1:0] chk_q[$];

    bp_port_arbiter #(.IDX_W(7), .QDEPTH(4), .STARVE_MAX(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .if_req         (if_req),
        .if_idx         (if_idx),
        .if_gnt         (if_gnt),
        .if_stall       (if_stall),
        .ex_valid       (ex_valid),
        .ex_stall       (ex_stall),
        .ex_idx         (ex_idx),
        .ex_taken       (ex_taken),
        .ex_local_pred  (ex_local_pred),
        .ex_global_pred (ex_global_pred),
        .pht_en         (pht_en),
        .pht_we         (pht_we),
        .pht_addr       (pht_addr),
        .pht_taken      (pht_taken),
        .chooser_upd    (chooser_upd),
        .correctness    (correctness),
        .q_count        (q_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            passed++;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic push_set(input logic [6:0] idx, input logic t, input logic lp, input logic gp);
        ex_valid       = 1'b1;
        ex_stall       = 1'b0;
        ex_idx         = idx;
        ex_taken       = t;
        ex_local_pred  = lp;
        ex_global_pred = gp;
        upd_q.push_back({idx, t});
        chk_q.push_back({lp == t, gp == t});
        $display("push idx=%0d taken=%0d local=%0d global=%0d", idx, t, lp, gp);
    endtask

    task automatic idle_ex();
        ex_valid = 1'b0;
        ex_stall = 1'b0;
    endtask

    // Monitor: every PHT write and every chooser strobe must match the next queued expectation.
    initial begin
        logic [7:0] exp_w;
        logic [1:0] exp_c;
        forever begin
            @(negedge clk);
            if (pht_we && !pht_en) chk("we_without_en", {31'd0, pht_en}, 32'd1);
            if (pht_en && pht_we) begin
                if (upd_q.size() == 0) begin
                    chk("unexpected_pht_write", {24'd0, pht_addr, pht_taken}, 32'hFFFF_FFFF);
                end else begin
                    exp_w = upd_q.pop_front();
                    $display("pht write addr=%0d taken=%0d", pht_addr, pht_taken);
                    chk("pht_write", {24'd0, pht_addr, pht_taken}, {24'd0, exp_w});
                end
            end
            if (chooser_upd) begin
                if (chk_q.size() == 0) begin
                    chk("unexpected_chooser_upd", {30'd0, correctness}, 32'hFFFF_FFFF);
                end else begin
                    exp_c = chk_q.pop_front();
                    $display("chooser_upd correctness=%b", correctness);
                    chk("correctness", {30'd0, correctness}, {30'd0, exp_c});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset then idle
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        neg();
        chk("rst_q_count", {29'd0, q_count}, 32'd0);
        chk("rst_pht_en", {31'd0, pht_en}, 32'd0);
        chk("rst_pht_we", {31'd0, pht_we}, 32'd0);
        chk("rst_if_gnt", {31'd0, if_gnt}, 32'd0);
        chk("rst_if_stall", {31'd0, if_stall}, 32'd0);
        chk("rst_chooser_upd", {31'd0, chooser_upd}, 32'd0);
        chk("rst_correctness", {30'd0, correctness}, 32'd0);
        cyc();

        // Single push with idle fetch: written the next cycle
        if_req = 1'b0;
        push_set(7'd5, 1'b1, 1'b1, 1'b0);
        neg();
        chk("p1_no_same_cycle_write", {31'd0, pht_we}, 32'd0);
        cyc();
        idle_ex();
        neg();
        chk("p1_q_count_1", {29'd0, q_count}, 32'd1);
        chk("p1_pht_we", {31'd0, pht_we}, 32'd1);
        cyc();
        neg();
        chk("p1_q_count_0", {29'd0, q_count}, 32'd0);
        chk("p1_idle_pht_en", {31'd0, pht_en}, 32'd0);
        cyc();

        // Fetch held: four pushes fill the FIFO, fifth push coincides with forced pop
        if_req = 1'b1;
        if_idx = 7'd9;
        for (int i = 0; i < 4; i++) begin
            push_set(7'(10 + i), 1'(i), 1'b1, 1'b1);
            neg();
            chk("fill_if_gnt", {31'd0, if_gnt}, 32'd1);
            chk("fill_if_stall", {31'd0, if_stall}, 32'd0);
            chk("fill_q_count", {29'd0, q_count}, 32'(i));
            chk("fill_lookup_addr", {25'd0, pht_addr}, 32'd9);
            cyc();
        end
        push_set(7'd14, 1'b1, 1'b0, 1'b0);
        neg();
        chk("full_q_count", {29'd0, q_count}, 32'd4);
        chk("full_if_stall", {31'd0, if_stall}, 32'd1);
        chk("full_if_gnt", {31'd0, if_gnt}, 32'd0);
        cyc();
        idle_ex();
        neg();
        chk("full_push_pop_count", {29'd0, q_count}, 32'd4);
        cyc();
        if_req = 1'b0;
        for (int i = 0; i < 3; i++) cyc();
        neg();
        chk("drain_q_count", {29'd0, q_count}, 32'd0);
        cyc();

        // Starvation: single queued update behind continuous fetch
        if_req = 1'b1;
        if_idx = 7'd33;
        push_set(7'd20, 1'b0, 1'b1, 1'b0);
        neg();
        chk("starve_push_gnt", {31'd0, if_gnt}, 32'd1);
        cyc();
        idle_ex();
        for (int i = 1; i <= 8; i++) begin
            neg();
            chk("starve_wait_gnt", {31'd0, if_gnt}, 32'd1);
            chk("starve_wait_count", {29'd0, q_count}, 32'd1);
            cyc();
        end
        neg();
        chk("flush_if_stall", {31'd0, if_stall}, 32'd1);
        chk("flush_pht_we", {31'd0, pht_we}, 32'd1);
        cyc();
        neg();
        chk("flush_done_count", {29'd0, q_count}, 32'd0);
        chk("flush_done_gnt", {31'd0, if_gnt}, 32'd1);
        cyc();

        // Stalled EX: no push, no chooser strobe
        if_req = 1'b0;
        ex_valid = 1'b1;
        ex_stall = 1'b1;
        ex_idx = 7'd40;
        ex_taken = 1'b1;
        neg();
        chk("stall_pht_en", {31'd0, pht_en}, 32'd0);
        cyc();
        idle_ex();
        neg();
        chk("stall_chooser_upd", {31'd0, chooser_upd}, 32'd0);
        chk("stall_q_count", {29'd0, q_count}, 32'd0);
        cyc();

        // Reset during FLUSH with three queued updates
        if_req = 1'b1;
        if_idx = 7'd50;
        for (int i = 0; i < 3; i++) begin
            push_set(7'(60 + i), 1'b1, 1'b1, 1'b0);
            neg();
            chk("rf_fill_gnt", {31'd0, if_gnt}, 32'd1);
            cyc();
        end
        idle_ex();
        for (int i = 0; i < 6; i++) begin
            neg();
            chk("rf_wait_gnt", {31'd0, if_gnt}, 32'd1);
            chk("rf_wait_count", {29'd0, q_count}, 32'd3);
            cyc();
        end
        rst_n = 1'b0;
        neg();
        chk("rf_flush_stall", {31'd0, if_stall}, 32'd1);
        chk("rf_flush_count", {29'd0, q_count}, 32'd3);
        cyc();
        rst_n = 1'b1;
        upd_q.delete();
        if_req = 1'b0;
        neg();
        chk("rf_after_count", {29'd0, q_count}, 32'd0);
        chk("rf_after_pht_en", {31'd0, pht_en}, 32'd0);
        chk("rf_after_chooser", {31'd0, chooser_upd}, 32'd0);
        cyc();
        if_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            neg();
            chk("rf_normal_gnt", {31'd0, if_gnt}, 32'd1);
            chk("rf_normal_stall", {31'd0, if_stall}, 32'd0);
            cyc();
        end
        if_req = 1'b0;
        cyc();

        neg();
        chk("sb_upd_q_empty", 32'(upd_q.size()), 32'd0);
        chk("sb_chk_q_empty", 32'(chk_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
